// File: rtl/mmm_pkg.sv
// Shared definitions for the Montgomery multiply sequencer: default widths,
// multiplier latency and the FSM state encoding.
package mmm_pkg;

    localparam int IDW_DEF     = 90;
    localparam int ODW_DEF     = 181;
    localparam int MUL_LAT_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL_T = 3'd1,
        ST_MUL_M = 3'd2,
        ST_MUL_U = 3'd3,
        ST_ADD   = 3'd4,
        ST_SUB   = 3'd5,
        ST_DONE  = 3'd6
    } mmm_state_t;

endpackage

// File: rtl/mmm_seq_ctrl.sv
// Montgomery product sequencer: drives an external fixed-latency multiplier
// through T = a*b, m = T*n', P = m*n, then reduces (T + P) / R into o_res.
module mmm_seq_ctrl
    import mmm_pkg::*;
#(
    parameter int IDW     = IDW_DEF,
    parameter int ODW     = ODW_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic           i_start,
    input  logic [IDW-1:0] i_a,
    input  logic [IDW-1:0] i_b,
    input  logic [IDW-1:0] i_n,
    input  logic [IDW-1:0] i_nprime,
    output logic [IDW-1:0] o_mul_a,
    output logic [IDW-1:0] o_mul_b,
    input  logic [ODW-1:0] i_mul_res,
    output logic           o_busy,
    output logic           o_done,
    output logic [IDW-1:0] o_res
);

    localparam int CNT_W = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT);

    mmm_state_t       state;
    mmm_state_t       next_state;
    logic [CNT_W-1:0] cnt;
    logic [IDW-1:0]   a_r;
    logic [IDW-1:0]   b_r;
    logic [IDW-1:0]   n_r;
    logic [IDW-1:0]   np_r;
    logic [2*IDW-1:0] t_r;
    logic [IDW-1:0]   m_r;
    logic [2*IDW-1:0] p_r;
    logic [IDW:0]     u_r;
    logic             in_mul;
    logic             mul_last;
    logic             accept;

    assign in_mul   = (state == ST_MUL_T) || (state == ST_MUL_M) || (state == ST_MUL_U);
    assign mul_last = in_mul && (cnt == CNT_LAST);
    assign accept   = i_start && ((state == ST_IDLE) || (state == ST_DONE));

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (i_start)  next_state = ST_MUL_T;
            ST_MUL_T: if (mul_last) next_state = ST_MUL_M;
            ST_MUL_M: if (mul_last) next_state = ST_MUL_U;
            ST_MUL_U: if (mul_last) next_state = ST_ADD;
            ST_ADD:   next_state = ST_SUB;
            ST_SUB:   next_state = ST_DONE;
            ST_DONE:  next_state = i_start ? ST_MUL_T : ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_mul_a = '0;
        o_mul_b = '0;
        o_busy  = 1'b1;
        o_done  = 1'b0;
        case (state)
            ST_IDLE: o_busy = 1'b0;
            ST_MUL_T: begin
                o_mul_a = a_r;
                o_mul_b = b_r;
            end
            ST_MUL_M: begin
                o_mul_a = t_r[IDW-1:0];
                o_mul_b = np_r;
            end
            ST_MUL_U: begin
                o_mul_a = m_r;
                o_mul_b = n_r;
            end
            ST_DONE: begin
                o_busy = 1'b0;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

    // The counter restarts at every phase change, so a product still in the
    // multiplier pipe from an aborted run can never line up with a capture.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            cnt <= '0;
        end else if (in_mul && !mul_last) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            a_r   <= '0;
            b_r   <= '0;
            n_r   <= '0;
            np_r  <= '0;
            t_r   <= '0;
            m_r   <= '0;
            p_r   <= '0;
            u_r   <= '0;
            o_res <= '0;
        end else begin
            if (accept) begin
                a_r  <= i_a;
                b_r  <= i_b;
                n_r  <= i_n;
                np_r <= i_nprime;
            end
            if (mul_last && (state == ST_MUL_T)) t_r <= (2*IDW)'(i_mul_res);
            if (mul_last && (state == ST_MUL_M)) m_r <= IDW'(i_mul_res);
            if (mul_last && (state == ST_MUL_U)) p_r <= (2*IDW)'(i_mul_res);
            // Keep the carry of T + P: U can reach 2N-1, one bit wider than N.
            if (state == ST_ADD) begin
                u_r <= (IDW+1)'(({1'b0, t_r} + {1'b0, p_r}) >> IDW);
            end
            if (state == ST_SUB) begin
                if (u_r >= {1'b0, n_r}) begin
                    o_res <= IDW'(u_r - {1'b0, n_r});
                end else begin
                    o_res <= IDW'(u_r);
                end
            end
        end
    end

endmodule

// File: tb/tb_mmm_seq_ctrl.sv
// Bench for mmm_seq_ctrl: pipelined multiplier model plus a reference that
// computes a*b*R^-1 mod N by repeated modular halving.
module tb_mmm_seq_ctrl;

    localparam int IDW     = 90;
    localparam int ODW     = 181;
    localparam int MUL_LAT = 4;
    localparam int LAT     = 3 * (MUL_LAT + 1) + 2;
    localparam int N_RAND  = 2000;

    localparam logic [IDW-1:0] N_FIX  = (90'd1 << 89) + 90'd1;
    localparam logic [IDW-1:0] NP_FIX = (90'd1 << 89) - 90'd1;
    localparam logic [IDW-1:0] R_MOD  = (90'd1 << 89) - 90'd1;
    localparam logic [IDW-1:0] HALF   = 90'd1 << 88;

    logic           clk = 1'b0;
    logic           rstn;
    logic           start;
    logic [IDW-1:0] a, b, n, nprime;
    logic [IDW-1:0] mul_a, mul_b;
    logic [ODW-1:0] mul_res;
    logic           busy, done;
    logic [IDW-1:0] res;
    logic [ODW-1:0] pipe [MUL_LAT];

    int vectors     = 0;
    int miscompares = 0;
    int sub_hits    = 0;

    mmm_seq_ctrl #(.IDW(IDW), .ODW(ODW), .MUL_LAT(MUL_LAT)) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_start   (start),
        .i_a       (a),
        .i_b       (b),
        .i_n       (n),
        .i_nprime  (nprime),
        .o_mul_a   (mul_a),
        .o_mul_b   (mul_b),
        .i_mul_res (mul_res),
        .o_busy    (busy),
        .o_done    (done),
        .o_res     (res)
    );

    always #5 clk = ~clk;

    // External multiplier: product appears MUL_LAT cycles after its operands.
    always @(posedge clk) begin
        pipe[0] <= ODW'(mul_a) * ODW'(mul_b);
        for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_res = pipe[MUL_LAT-1];

    function automatic logic [IDW-1:0] mont_ref(input logic [IDW-1:0] x_a, x_b, x_n);
        logic [2*IDW-1:0] prod;
        logic [IDW:0]     y;
        logic [IDW-1:0]   x;
        prod = {{IDW{1'b0}}, x_a} * {{IDW{1'b0}}, x_b};
        x = IDW'(prod % {{IDW{1'b0}}, x_n});
        for (int i = 0; i < IDW; i++) begin
            y = {1'b0, x};
            if (y[0]) y = y + {1'b0, x_n};
            x = IDW'(y >> 1);
        end
        return x;
    endfunction

    function automatic logic [IDW-1:0] neg_inv(input logic [IDW-1:0] x_n);
        logic [IDW-1:0] inv;
        inv = x_n;
        for (int i = 0; i < 7; i++) inv = inv * (IDW'(2) - x_n * inv);
        return IDW'(0) - inv;
    endfunction

    // True when (ab + mN)/R lands in [N, 2N) and needs the final subtract.
    function automatic bit needs_sub(input logic [IDW-1:0] x_a, x_b, x_n, x_np);
        logic [2*IDW-1:0] t;
        logic [IDW-1:0]   m;
        logic [2*IDW+1:0] s;
        t = {{IDW{1'b0}}, x_a} * {{IDW{1'b0}}, x_b};
        m = t[IDW-1:0] * x_np;
        s = (2*IDW+2)'(t) + (2*IDW+2)'(m) * (2*IDW+2)'(x_n);
        return (s >> IDW) >= (2*IDW+2)'(x_n);
    endfunction

    function automatic logic [IDW-1:0] rand_w();
        return IDW'({$urandom, $urandom, $urandom});
    endfunction

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [IDW-1:0] x_a, x_b, x_n, x_np);
        @(negedge clk);
        start  = 1'b1;
        a      = x_a;
        b      = x_b;
        n      = x_n;
        nprime = x_np;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (done === 1'b1) break;
        end
        check_output({tag, " latency"}, 128'(lat), 128'(exp_lat));
    endtask

    task automatic run_op(input logic [IDW-1:0] x_a, x_b, x_n, x_np,
                          input logic [IDW-1:0] exp, input string tag);
        apply_stimulus(x_a, x_b, x_n, x_np);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = rand_w();
        b     = rand_w();
        check_output({tag, " busy"}, 128'(busy), 128'(1));
        check_output({tag, " mul_a"}, 128'(mul_a), 128'(x_a));
        check_output({tag, " mul_b"}, 128'(mul_b), 128'(x_b));
        wait_done(tag, LAT);
        check_output({tag, " res"}, 128'(res), 128'(exp));
        @(posedge clk);
        #1;
        check_output({tag, " done pulse"}, 128'(done), 128'(0));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [IDW-1:0] bb_a [4];
        logic [IDW-1:0] bb_b [4];
        logic [IDW-1:0] rn, rnp, ra, rb;

        rstn   = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        n      = '0;
        nprime = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset busy",  128'(busy),  128'(0));
        check_output("reset done",  128'(done),  128'(0));
        check_output("reset res",   128'(res),   128'(0));
        check_output("reset mul_a", 128'(mul_a), 128'(0));
        check_output("reset mul_b", 128'(mul_b), 128'(0));
        @(negedge clk);
        rstn = 1'b1;

        run_op(90'd1, 90'd1, N_FIX, NP_FIX, HALF, "one_one");
        check_output("idle mul_a", 128'(mul_a), 128'(0));
        run_op(R_MOD, 90'd1, N_FIX, NP_FIX, 90'd1, "rmod_one");
        run_op(N_FIX - 90'd1, N_FIX - 90'd1, N_FIX, NP_FIX, HALF, "nm1_nm1");
        run_op(90'd0, 90'd5, N_FIX, NP_FIX, 90'd0, "zero_five");

        // Start held high; next operands are changed while the current run is busy.
        bb_a[0] = 90'd1;          bb_b[0] = 90'd1;
        bb_a[1] = R_MOD;          bb_b[1] = 90'd1;
        bb_a[2] = rand_w() >> 2;  bb_b[2] = 90'd7;
        bb_a[3] = 90'd3;          bb_b[3] = 90'd3;
        apply_stimulus(bb_a[0], bb_b[0], N_FIX, NP_FIX);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            repeat (3) @(posedge clk);
            #1;
            a = bb_a[k+1];
            b = bb_b[k+1];
            wait_done($sformatf("b2b%0d", k), LAT - 3);
            check_output($sformatf("b2b%0d res", k), 128'(res),
                         128'(mont_ref(bb_a[k], bb_b[k], N_FIX)));
            if (k == 2) start = 1'b0;
            @(posedge clk);
            #1;
            check_output($sformatf("b2b%0d pulse", k), 128'(done), 128'(0));
            check_output($sformatf("b2b%0d restart", k), 128'(busy), 128'(k != 2));
        end

        // Abort during MUL_M, then a fresh run must ignore stale products.
        apply_stimulus(R_MOD, 90'd5, N_FIX, NP_FIX);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check_output("abort busy before", 128'(busy), 128'(1));
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check_output("abort busy",  128'(busy),  128'(0));
        check_output("abort done",  128'(done),  128'(0));
        check_output("abort res",   128'(res),   128'(0));
        check_output("abort mul_a", 128'(mul_a), 128'(0));
        @(negedge clk);
        rstn = 1'b1;
        run_op(90'd1, 90'd1, N_FIX, NP_FIX, HALF, "after_abort");

        for (int i = 0; i < N_RAND; i++) begin
            rn = rand_w() | 90'd1;
            if (rn < 90'd3) rn = 90'd3;
            rnp = neg_inv(rn);
            ra  = rand_w() % rn;
            rb  = rand_w() % rn;
            if (needs_sub(ra, rb, rn, rnp)) sub_hits++;
            run_op(ra, rb, rn, rnp, mont_ref(ra, rb, rn), $sformatf("rand%0d", i));
        end
        $display("[TB] subtract branch taken in %0d of %0d random operations", sub_hits, N_RAND);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
